// File: rtl/cpu_defs_pkg.sv
// Shared decode definitions: alu_op bit positions, MIPS opcode/funct codes, ALU control bundle.
// ID_ALU_DECODE_RI_EN adds a reserved-instruction flag to the bundle.
package cpu_defs;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  typedef logic [11:0] alu_op_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    alu_op_t    alu_op;
    logic       src1_is_sa;
    logic       src1_is_pc;
    logic       src2_is_simm;
    logic       src2_is_zimm;
    logic       src2_is_8;
    logic       alu_ov;
    logic [4:0] dest;
    logic       gr_we;
`ifdef ID_ALU_DECODE_RI_EN
    logic       ri;
`endif
  } alu_ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational MIPS instruction -> ALU control bundle decoder.
// ID_ALU_DECODE_RI_EN flags unknown encodings and SLL-family with rs != 0.
module alu_ctrl_decode
  import cpu_defs::*;
(
  input  logic [31:0] inst,
  output alu_ctrl_t   ctrl
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       known;

  assign op    = inst[31:26];
  assign funct = inst[5:0];

  // sa field is carried to EXE through es_imm, not decoded here
`ifdef ID_ALU_DECODE_RI_EN
  logic unused_bits;
  assign unused_bits = ^inst[10:6];
  logic sll_rs_bad;
  assign sll_rs_bad = (op == OP_SPECIAL) && (inst[25:21] != 5'd0) &&
                      (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA);
`else
  logic unused_bits;
  assign unused_bits = ^{inst[25:21], inst[10:6]};
`endif

  always_comb begin
    ctrl  = '0;
    known = 1'b1;
    case (op)
      OP_SPECIAL: begin
        ctrl.dest  = inst[15:11];
        ctrl.gr_we = 1'b1;
        case (funct)
          FN_ADD:  begin ctrl.alu_op[ALU_ADD] = 1'b1; ctrl.alu_ov = 1'b1; end
          FN_ADDU: ctrl.alu_op[ALU_ADD] = 1'b1;
          FN_SUB:  begin ctrl.alu_op[ALU_SUB] = 1'b1; ctrl.alu_ov = 1'b1; end
          FN_SUBU: ctrl.alu_op[ALU_SUB] = 1'b1;
          FN_SLT:  ctrl.alu_op[ALU_SLT] = 1'b1;
          FN_SLTU: ctrl.alu_op[ALU_SLTU] = 1'b1;
          FN_AND:  ctrl.alu_op[ALU_AND] = 1'b1;
          FN_OR:   ctrl.alu_op[ALU_OR] = 1'b1;
          FN_XOR:  ctrl.alu_op[ALU_XOR] = 1'b1;
          FN_NOR:  ctrl.alu_op[ALU_NOR] = 1'b1;
          FN_SLL:  begin ctrl.alu_op[ALU_SLL] = 1'b1; ctrl.src1_is_sa = 1'b1; end
          FN_SRL:  begin ctrl.alu_op[ALU_SRL] = 1'b1; ctrl.src1_is_sa = 1'b1; end
          FN_SRA:  begin ctrl.alu_op[ALU_SRA] = 1'b1; ctrl.src1_is_sa = 1'b1; end
          FN_SLLV: ctrl.alu_op[ALU_SLL] = 1'b1;
          FN_SRLV: ctrl.alu_op[ALU_SRL] = 1'b1;
          FN_SRAV: ctrl.alu_op[ALU_SRA] = 1'b1;
          FN_JALR: begin
            ctrl.alu_op[ALU_ADD] = 1'b1;
            ctrl.src1_is_pc      = 1'b1;
            ctrl.src2_is_8       = 1'b1;
          end
          default: known = 1'b0;
        endcase
      end
      OP_JAL: begin
        ctrl.alu_op[ALU_ADD] = 1'b1;
        ctrl.src1_is_pc      = 1'b1;
        ctrl.src2_is_8       = 1'b1;
        ctrl.dest            = 5'd31;
        ctrl.gr_we           = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.dest  = inst[20:16];
        ctrl.gr_we = 1'b1;
        case (op)
          OP_ADDI:  begin ctrl.alu_op[ALU_ADD] = 1'b1; ctrl.alu_ov = 1'b1; ctrl.src2_is_simm = 1'b1; end
          OP_ADDIU: begin ctrl.alu_op[ALU_ADD] = 1'b1; ctrl.src2_is_simm = 1'b1; end
          OP_SLTI:  begin ctrl.alu_op[ALU_SLT] = 1'b1; ctrl.src2_is_simm = 1'b1; end
          OP_SLTIU: begin ctrl.alu_op[ALU_SLTU] = 1'b1; ctrl.src2_is_simm = 1'b1; end
          OP_ANDI:  begin ctrl.alu_op[ALU_AND] = 1'b1; ctrl.src2_is_zimm = 1'b1; end
          OP_ORI:   begin ctrl.alu_op[ALU_OR] = 1'b1; ctrl.src2_is_zimm = 1'b1; end
          OP_XORI:  begin ctrl.alu_op[ALU_XOR] = 1'b1; ctrl.src2_is_zimm = 1'b1; end
          default:  begin ctrl.alu_op[ALU_LUI] = 1'b1; ctrl.src2_is_zimm = 1'b1; end
        endcase
      end
      default: known = 1'b0;
    endcase

    // unknown encodings still travel down the pipe, but as a no-op bundle
    if (!known) ctrl = '0;

`ifdef ID_ALU_DECODE_RI_EN
    ctrl.ri = ~known | sll_rs_bad;
    if (ctrl.ri) ctrl.gr_we = 1'b0;
`endif
  end

endmodule

// File: rtl/id_alu_decode.sv
// ID/EXE pipeline register holding the decoded ALU control bundle with valid/allowin handshake.
// ID_ALU_DECODE_RI_EN adds the es_ri output.
module id_alu_decode
  import cpu_defs::*;
#(
  parameter bit PAYLOAD_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_valid,
  output logic        ds_allowin,
  input  logic [31:0] ds_inst,
  input  logic [31:0] ds_pc,
  input  logic [31:0] ds_rs_value,
  input  logic [31:0] ds_rt_value,
  input  logic        flush,
  input  logic        es_allowin,
  output logic        es_valid,
  output logic [11:0] es_alu_op,
  output logic        es_src1_is_sa,
  output logic        es_src1_is_pc,
  output logic        es_src2_is_simm,
  output logic        es_src2_is_zimm,
  output logic        es_src2_is_8,
  output logic        es_alu_ov,
  output logic [31:0] es_rs_value,
  output logic [31:0] es_rt_value,
  output logic [31:0] es_pc,
  output logic [15:0] es_imm,
  output logic [4:0]  es_dest,
`ifdef ID_ALU_DECODE_RI_EN
  output logic        es_ri,
`endif
  output logic        es_gr_we
);

  alu_ctrl_t ds_ctrl;
  alu_ctrl_t es_ctrl;
  logic      load;

  alu_ctrl_decode u_dec (
    .inst (ds_inst),
    .ctrl (ds_ctrl)
  );

  assign ds_allowin = resetn & (~es_valid | es_allowin);
  assign load       = ds_valid & ds_allowin & ~flush;

  always_ff @(posedge clk) begin
    if (!resetn)                  es_valid <= 1'b0;
    else if (flush)               es_valid <= 1'b0;
    else if (load)                es_valid <= 1'b1;
    else if (es_allowin)          es_valid <= 1'b0;
  end

  // load already excludes flush and reset, so a stalled bundle is never overwritten
  always_ff @(posedge clk) begin
    if (!resetn) begin
      if (PAYLOAD_RESET) begin
        es_ctrl     <= '0;
        es_rs_value <= '0;
        es_rt_value <= '0;
        es_pc       <= '0;
        es_imm      <= '0;
      end
    end else if (load) begin
      es_ctrl     <= ds_ctrl;
      es_rs_value <= ds_rs_value;
      es_rt_value <= ds_rt_value;
      es_pc       <= ds_pc;
      es_imm      <= ds_inst[15:0];
    end
  end

  assign es_alu_op       = es_ctrl.alu_op;
  assign es_src1_is_sa   = es_ctrl.src1_is_sa;
  assign es_src1_is_pc   = es_ctrl.src1_is_pc;
  assign es_src2_is_simm = es_ctrl.src2_is_simm;
  assign es_src2_is_zimm = es_ctrl.src2_is_zimm;
  assign es_src2_is_8    = es_ctrl.src2_is_8;
  assign es_alu_ov       = es_ctrl.alu_ov;
  assign es_dest         = es_ctrl.dest;
  assign es_gr_we        = es_ctrl.gr_we;
`ifdef ID_ALU_DECODE_RI_EN
  assign es_ri           = es_ctrl.ri;
`endif

endmodule

// File: tb/tb_id_alu_decode.sv
// Directed vector bench for id_alu_decode: decode table plus handshake/flush/reset sequences.
module tb_id_alu_decode;

  logic        clk = 1'b0;
  logic        resetn, ds_valid, flush, es_allowin;
  logic [31:0] ds_inst, ds_pc, ds_rs_value, ds_rt_value;
  logic        ds_allowin, es_valid;
  logic [11:0] es_alu_op;
  logic        es_src1_is_sa, es_src1_is_pc, es_src2_is_simm, es_src2_is_zimm, es_src2_is_8;
  logic        es_alu_ov, es_gr_we;
  logic [31:0] es_rs_value, es_rt_value, es_pc;
  logic [15:0] es_imm;
  logic [4:0]  es_dest;
`ifdef ID_ALU_DECODE_RI_EN
  logic        es_ri;
`endif

  always #5 clk = ~clk;

  id_alu_decode #(.PAYLOAD_RESET(1'b1)) dut (
    .clk(clk), .resetn(resetn), .ds_valid(ds_valid), .ds_allowin(ds_allowin),
    .ds_inst(ds_inst), .ds_pc(ds_pc), .ds_rs_value(ds_rs_value), .ds_rt_value(ds_rt_value),
    .flush(flush), .es_allowin(es_allowin), .es_valid(es_valid), .es_alu_op(es_alu_op),
    .es_src1_is_sa(es_src1_is_sa), .es_src1_is_pc(es_src1_is_pc),
    .es_src2_is_simm(es_src2_is_simm), .es_src2_is_zimm(es_src2_is_zimm),
    .es_src2_is_8(es_src2_is_8), .es_alu_ov(es_alu_ov), .es_rs_value(es_rs_value),
    .es_rt_value(es_rt_value), .es_pc(es_pc), .es_imm(es_imm), .es_dest(es_dest),
`ifdef ID_ALU_DECODE_RI_EN
    .es_ri(es_ri),
`endif
    .es_gr_we(es_gr_we)
  );

  typedef struct {
    logic [31:0] inst;
    logic [11:0] op;
    logic [4:0]  sel;   // {src1_is_sa, src1_is_pc, src2_is_simm, src2_is_zimm, src2_is_8}
    logic        ov;
    logic [4:0]  dest;
    logic        we;    // value without the reserved-instruction override
    logic        ri;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [4:0] sel_now();
    return {es_src1_is_sa, es_src1_is_pc, es_src2_is_simm, es_src2_is_zimm, es_src2_is_8};
  endfunction

  initial begin
    tbl[0]  = '{32'h2128FFFF, 12'h001, 5'b00100, 1'b1, 5'd8,  1'b1, 1'b0}; // ADDI
    tbl[1]  = '{32'h00094100, 12'h100, 5'b10000, 1'b0, 5'd8,  1'b1, 1'b0}; // SLL
    tbl[2]  = '{32'h3C081234, 12'h800, 5'b00010, 1'b0, 5'd8,  1'b1, 1'b0}; // LUI
    tbl[3]  = '{32'h0C000010, 12'h001, 5'b01001, 1'b0, 5'd31, 1'b1, 1'b0}; // JAL
    tbl[4]  = '{32'hFC000000, 12'h000, 5'b00000, 1'b0, 5'd0,  1'b0, 1'b1}; // undefined op
    tbl[5]  = '{32'h00221820, 12'h001, 5'b00000, 1'b1, 5'd3,  1'b1, 1'b0}; // ADD
    tbl[6]  = '{32'h00A62023, 12'h002, 5'b00000, 1'b0, 5'd4,  1'b1, 1'b0}; // SUBU
    tbl[7]  = '{32'h0022182B, 12'h008, 5'b00000, 1'b0, 5'd3,  1'b1, 1'b0}; // SLTU
    tbl[8]  = '{32'h00221827, 12'h020, 5'b00000, 1'b0, 5'd3,  1'b1, 1'b0}; // NOR
    tbl[9]  = '{32'h00221807, 12'h400, 5'b00000, 1'b0, 5'd3,  1'b1, 1'b0}; // SRAV
    tbl[10] = '{32'h0020F809, 12'h001, 5'b01001, 1'b0, 5'd31, 1'b1, 1'b0}; // JALR
    tbl[11] = '{32'h352800FF, 12'h040, 5'b00010, 1'b0, 5'd8,  1'b1, 1'b0}; // ORI
    tbl[12] = '{32'h2928FFFF, 12'h004, 5'b00100, 1'b0, 5'd8,  1'b1, 1'b0}; // SLTI
    tbl[13] = '{32'h0000003F, 12'h000, 5'b00000, 1'b0, 5'd0,  1'b0, 1'b1}; // undefined funct
    tbl[14] = '{32'h00220021, 12'h001, 5'b00000, 1'b0, 5'd0,  1'b1, 1'b0}; // ADDU to $0
    tbl[15] = '{32'h00294100, 12'h100, 5'b10000, 1'b0, 5'd8,  1'b1, 1'b1}; // SLL, rs != 0
    tbl[16] = '{32'h00094103, 12'h400, 5'b10000, 1'b0, 5'd8,  1'b1, 1'b0}; // SRA

    // reset with an instruction offered
    resetn = 1'b0; ds_valid = 1'b1; flush = 1'b0; es_allowin = 1'b1;
    ds_inst = 32'h2128FFFF; ds_pc = 32'h1234; ds_rs_value = 32'h1; ds_rt_value = 32'h2;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_es_valid", {31'd0, es_valid}, 32'd0);
    chk("rst_ds_allowin", {31'd0, ds_allowin}, 32'd0);
    chk("rst_alu_op", {20'd0, es_alu_op}, 32'd0);
    chk("rst_pc", es_pc, 32'd0);
    chk("rst_gr_we", {31'd0, es_gr_we}, 32'd0);

    // decode table, streamed at one per cycle
    @(negedge clk); resetn = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      ds_inst = tbl[i].inst; ds_pc = 32'hBFC00000 + 32'(i * 4);
      ds_rs_value = 32'hA0000000 | 32'(i); ds_rt_value = 32'hB0000000 | 32'(i);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), {31'd0, es_valid}, 32'd1);
      chk($sformatf("v%0d_alu_op", i), {20'd0, es_alu_op}, {20'd0, tbl[i].op});
      chk($sformatf("v%0d_sel", i), {27'd0, sel_now()}, {27'd0, tbl[i].sel});
      chk($sformatf("v%0d_ov", i), {31'd0, es_alu_ov}, {31'd0, tbl[i].ov});
      chk($sformatf("v%0d_dest", i), {27'd0, es_dest}, {27'd0, tbl[i].dest});
`ifdef ID_ALU_DECODE_RI_EN
      chk($sformatf("v%0d_we", i), {31'd0, es_gr_we}, {31'd0, tbl[i].we & ~tbl[i].ri});
      chk($sformatf("v%0d_ri", i), {31'd0, es_ri}, {31'd0, tbl[i].ri});
`else
      chk($sformatf("v%0d_we", i), {31'd0, es_gr_we}, {31'd0, tbl[i].we});
`endif
      chk($sformatf("v%0d_imm", i), {16'd0, es_imm}, {16'd0, tbl[i].inst[15:0]});
      chk($sformatf("v%0d_pc", i), es_pc, 32'hBFC00000 + 32'(i * 4));
      chk($sformatf("v%0d_rs", i), es_rs_value, 32'hA0000000 | 32'(i));
      chk($sformatf("v%0d_rt", i), es_rt_value, 32'hB0000000 | 32'(i));
    end

    // drain: nothing offered, EXE takes the bundle
    @(negedge clk); ds_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_valid", {31'd0, es_valid}, 32'd0);

    // stall: EXE blocked for 3 cycles with a new instruction waiting
    @(negedge clk); ds_valid = 1'b1; es_allowin = 1'b0; ds_inst = 32'h2128FFFF; ds_pc = 32'h100;
    @(posedge clk); #1;
    chk("stall_load_valid", {31'd0, es_valid}, 32'd1);
    @(negedge clk); ds_inst = 32'h352800FF; ds_pc = 32'h200;
    #1 chk("stall_allowin", {31'd0, ds_allowin}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", c), {31'd0, es_valid}, 32'd1);
      chk($sformatf("stall%0d_pc", c), es_pc, 32'h100);
      chk($sformatf("stall%0d_alu_op", c), {20'd0, es_alu_op}, 32'h001);
    end
    @(negedge clk); es_allowin = 1'b1;
    #1 chk("unstall_allowin", {31'd0, ds_allowin}, 32'd1);
    @(posedge clk); #1;
    chk("unstall_pc", es_pc, 32'h200);
    chk("unstall_alu_op", {20'd0, es_alu_op}, 32'h040);

    // back-to-back streaming
    begin
      int nvalid = 0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk); ds_inst = tbl[i].inst; ds_pc = 32'h300 + 32'(i);
        @(posedge clk); #1;
        if (es_valid === 1'b1 && es_pc === 32'h300 + 32'(i)) nvalid++;
      end
      chk("stream_count", nvalid, 32'd4);
    end

    // flush drops the held and the incoming instruction; payload holds
    @(negedge clk); flush = 1'b1; ds_inst = 32'h3C081234; ds_pc = 32'h400;
    @(posedge clk); #1;
    chk("flush_valid", {31'd0, es_valid}, 32'd0);
    chk("flush_pc_hold", es_pc, 32'h303);
    @(negedge clk); flush = 1'b0; ds_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_flush_valid", {31'd0, es_valid}, 32'd0);

    // reset mid-stream
    @(negedge clk); ds_valid = 1'b1; ds_inst = 32'h0C000010; ds_pc = 32'hBFC00000;
    @(posedge clk); #1;
    chk("jal_valid", {31'd0, es_valid}, 32'd1);
    chk("jal_pc", es_pc, 32'hBFC00000);
    @(negedge clk); resetn = 1'b0;
    #1 chk("midrst_allowin", {31'd0, ds_allowin}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_valid", {31'd0, es_valid}, 32'd0);
    chk("midrst_pc", es_pc, 32'd0);
    chk("midrst_alu_op", {20'd0, es_alu_op}, 32'd0);
    chk("midrst_dest", {27'd0, es_dest}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_alu_decode.md
Name: id_alu_decode

Overview:
- Decode-stage block that turns a MIPS instruction into the ALU control bundle the EXE-stage ALU consumes: one-hot alu_op, source selects, imm, and the overflow-check flag.
- Also produces the destination register and write enable.
- Holds the bundle in the ID/EXE pipeline register, using a valid/allowin handshake and flush.
- Sits between the ID operand read and the EXE stage.

Parameters:
PAYLOAD_RESET, 1, 1 = payload registers cleared on reset; 0 = only es_valid is reset and payload is don't-care until the first load.

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
ds_valid  in  1  ID holds a valid instruction
ds_allowin  out  1  block accepts the ID instruction this cycle
ds_inst  in  32  instruction word
ds_pc  in  32  instruction PC
ds_rs_value  in  32  GPR[rs]
ds_rt_value  in  32  GPR[rt]
flush  in  1  discard the held and the incoming instruction
es_allowin  in  1  EXE accepts the bundle this cycle
es_valid  out  1  bundle valid
es_alu_op  out  12  one-hot: [0]add [1]sub [2]slt [3]sltu [4]and [5]nor [6]or [7]xor [8]sll [9]srl [10]sra [11]lui
es_src1_is_sa / es_src1_is_pc / es_src2_is_simm / es_src2_is_zimm / es_src2_is_8  out  1 each  operand selects
es_alu_ov  out  1  overflow check enabled
es_rs_value / es_rt_value / es_pc  out  32 each  registered operands and PC
es_imm  out  16  inst[15:0]
es_dest  out  5  destination GPR
es_gr_we  out  1  GPR write enable

Behaviour:
- Reset (resetn=0 at a clk edge): es_valid=0. With PAYLOAD_RESET=1, all es_* payload outputs = 0.
- ds_allowin = ~es_valid | es_allowin. It is combinational and is forced to 0 while resetn=0.
- Load condition is ds_valid & ds_allowin & ~flush.
  - On load, es_valid <= 1 at the next edge and the payload is captured.
  - Otherwise, if es_allowin & es_valid, then es_valid <= 0.
  - In all other cases, es_valid and the payload hold.
- Payload is stable whenever es_valid=1 & es_allowin=0.
- flush=1: es_valid <= 0 at the next edge, and any simultaneous incoming instruction is dropped. flush has priority over load.
- Reset has priority over flush and load.
- Latency: one cycle from ds_valid & ds_allowin to es_valid.
- Throughput: one instruction per cycle when es_allowin=1.
- Decode is combinational on ds_inst: op=inst[31:26], funct=inst[5:0].
- R-type (op=0), dest=rd, gr_we=1:
  - ADD 20 (ov), ADDU 21 → add; SUB 22 (ov), SUBU 23 → sub.
  - SLT 2A, SLTU 2B, AND 24, OR 25, XOR 26, NOR 27 → matching alu_op bit.
  - SLL 00, SRL 02, SRA 03 → shift bit with src1_is_sa.
  - SLLV 04, SRLV 06, SRAV 07 → shift bit, no selects (shift amount is rs_value[4:0]).
  - JALR 09 → add, src1_is_pc, src2_is_8.
- I-type, dest=rt, gr_we=1:
  - ADDI 08 (ov) and ADDIU 09 → add, simm; SLTI 0A → slt, simm; SLTIU 0B → sltu, simm.
  - ANDI 0C, ORI 0D, XORI 0E → zimm.
  - LUI 0F → lui, zimm.
- JAL 03: add, src1_is_pc, src2_is_8, dest=31, gr_we=1.
- Any other encoding: alu_op=0, all selects=0, alu_ov=0, gr_we=0, dest=0. It still travels as a valid bundle.
- Write to GPR 0: gr_we stays 1 and the register file ignores it.
- At most one alu_op bit and at most one src1 select / one src2 select are set.

Optional Feature:
ID_ALU_DECODE_RI_EN
- Defined: adds output es_ri (1 bit, reset 0), set for any encoding outside the table above and for SLL-family encodings with rs≠0. gr_we is forced to 0 when es_ri=1.
- Not defined: the port is absent and unknown encodings decode as described in Behaviour.

Decomposition:
- Shared package (cpu_defs): alu_op bit-index localparams, alu_op_t (logic[11:0]), opcode/funct localparams, and struct alu_ctrl_t {alu_op, five selects, alu_ov, dest, gr_we}.
- One sub-module, alu_ctrl_decode: purely combinational, ds_inst → alu_ctrl_t. The top level holds only handshake and registers.

Test Plan:
- 0x2128FFFF (ADDI $8,$9,-1), ds_valid=1, es_allowin=1 → next cycle es_valid=1, alu_op=0x001, src2_is_simm=1, alu_ov=1, imm=0xFFFF, dest=8, gr_we=1.
- 0x00094100 (SLL $8,$9,4) → alu_op=0x100, src1_is_sa=1, imm[10:6]=4, dest=8; then 0x3C081234 (LUI) → alu_op=0x800, src2_is_zimm=1.
- 0x0C000010 (JAL), ds_pc=0xBFC00000 → alu_op=0x001, src1_is_pc=1, src2_is_8=1, dest=31, es_pc=0xBFC00000.
- es_valid=1 and es_allowin held 0 for 3 cycles with a new ds_valid → ds_allowin=0, payload unchanged. es_allowin=1 → new bundle next cycle; back-to-back streaming of 4 instructions gives 4 consecutive valid cycles.
- flush=1 with es_valid=1 and ds_valid=1 → es_valid=0 next cycle, incoming dropped. resetn=0 mid-stream → es_valid=0 and payload=0 next cycle.
- 0xFC000000 (undefined) → alu_op=0, gr_we=0. With ID_ALU_DECODE_RI_EN defined, es_ri=1.
